// File: rtl/alu_logic_driver.sv
// Command-side initiator for the combinational logic unit: buffers op requests,
// drives the unit from registers, waits one settle cycle, returns results in order.
module alu_logic_driver #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_func,
    input  logic [W-1:0] cmd_x,
    input  logic [W-1:0] cmd_y,
    output logic [W-1:0] alu_x,
    output logic [W-1:0] alu_y,
    output logic [2:0]   alu_func,
    input  logic [W-1:0] alu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW       = $clog2(DEPTH + 1);
    localparam logic [2:0]  FUNC_MAX = 3'b100;

    typedef struct packed {
        logic [2:0]   func;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    cmd_t          fifo_mem [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;
    logic [W-1:0]  alu_x_nxt;
    logic [W-1:0]  alu_y_nxt;
    logic [2:0]    alu_func_nxt;
    logic          rsp_valid_nxt;
    logic [W-1:0]  rsp_data_nxt;
    logic          rsp_err_nxt;

    assign push      = cmd_valid & cmd_ready;
    assign head      = fifo_mem[rd_ptr];
    assign count_nxt = count + CW'(push) - CW'(pop);

    // Command storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{func: cmd_func, x: cmd_x, y: cmd_y};
        end
    end

    // Pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_nxt;
            cmd_ready <= (count_nxt != CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic; illegal codes never reach the unit.
    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        alu_x_nxt     = alu_x;
        alu_y_nxt     = alu_y;
        alu_func_nxt  = alu_func;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = rsp_err;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (head.func <= FUNC_MAX) begin
                        alu_x_nxt    = head.x;
                        alu_y_nxt    = head.y;
                        alu_func_nxt = head.func;
                        state_nxt    = DRIVE;
                    end else begin
                        rsp_data_nxt  = '0;
                        rsp_err_nxt   = 1'b1;
                        rsp_valid_nxt = 1'b1;
                        state_nxt     = RESP;
                    end
                end
            end
            DRIVE: begin
                rsp_data_nxt  = alu_result;
                rsp_err_nxt   = 1'b0;
                rsp_valid_nxt = 1'b1;
                state_nxt     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_x     <= '0;
            alu_y     <= '0;
            alu_func  <= 3'b000;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            alu_x     <= alu_x_nxt;
            alu_y     <= alu_y_nxt;
            alu_func  <= alu_func_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_alu_logic_driver.sv
// Randomized and directed bench for alu_logic_driver with an arithmetic
// reference model and a scoreboard of responses in command order.
module tb_alu_logic_driver;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_func;
    logic [W-1:0] cmd_x;
    logic [W-1:0] cmd_y;
    logic [W-1:0] alu_x;
    logic [W-1:0] alu_y;
    logic [2:0]   alu_func;
    logic [W-1:0] alu_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_count = 0;

    rsp_t         exp_q[$];
    logic [W-1:0] got_data[$];
    int           got_cyc[$];

    alu_logic_driver #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
        .cmd_x(cmd_x), .cmd_y(cmd_y),
        .alu_x(alu_x), .alu_y(alu_y), .alu_func(alu_func), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Combinational logic unit; illegal codes give a non-zero poison value.
    function automatic logic [W-1:0] unit_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic [2:0] f);
        logic [W-1:0] r;
        case (f)
            3'd0:    r = x & y;
            3'd1:    r = x ^ y;
            3'd2:    r = x << y;
            3'd3:    r = x >> y;
            3'd4:    r = $signed(x) >>> y;
            default: r = '1;
        endcase
        return r;
    endfunction

    assign alu_result = unit_model(alu_x, alu_y, alu_func);

    // Reference: shifts as multiply / floor-divide by powers of two.
    function automatic rsp_t ref_model(input logic [2:0] f, input logic [W-1:0] x,
                                       input logic [W-1:0] y);
        rsp_t            r;
        longint unsigned ux;
        longint unsigned pu;
        longint          sx;
        longint          ps;
        longint          q;
        r.err  = 1'b0;
        r.data = '0;
        ux     = 64'(x);
        sx     = longint'($signed(x));
        case (f)
            3'd0: r.data = x & y;
            3'd1: r.data = x ^ y;
            3'd2: begin
                if (y < W) begin
                    pu     = 64'd1 << y;
                    r.data = W'(ux * pu);
                end
            end
            3'd3: begin
                if (y < W) begin
                    pu     = 64'd1 << y;
                    r.data = W'(ux / pu);
                end
            end
            3'd4: begin
                if (y >= W) begin
                    r.data = (sx < 0) ? '1 : '0;
                end else begin
                    ps = longint'(1) << y;
                    q  = sx / ps;
                    if (sx < 0 && (sx % ps) != 0) q = q - 1;
                    r.data = W'(q);
                end
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Scoreboard monitor plus stall-stability tracking.
    logic         stall = 1'b0;
    logic [W-1:0] hold_data;
    logic         hold_err;
    always @(negedge clk) begin
        rsp_t e;
        if (!rst_n) begin
            exp_q.delete();
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", 64'(rsp_valid), 64'd1);
                chk("hold_data", 64'(rsp_data), 64'(hold_data));
                chk("hold_err", 64'(rsp_err), 64'(hold_err));
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                end
                got_data.push_back(rsp_data);
                got_cyc.push_back(cyc);
                rsp_count++;
            end
            stall     = rsp_valid && !rsp_ready;
            hold_data = rsp_data;
            hold_err  = rsp_err;
            if (cmd_valid && cmd_ready) exp_q.push_back(ref_model(cmd_func, cmd_x, cmd_y));
        end
    end

    task automatic send(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        bit ok = 1'b0;
        int n  = 0;
        cmd_valid = 1'b1;
        cmd_func  = f;
        cmd_x     = x;
        cmd_y     = y;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        chk("send_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 60);
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((exp_q.size() != 0 || rsp_valid) && n < 400);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic gen(output logic [2:0] f, output logic [W-1:0] x, output logic [W-1:0] y);
        f = 3'($urandom_range(0, 4));
        x = $urandom;
        y = (f >= 3'd2) ? W'($urandom_range(0, 63)) : W'($urandom);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           base;
        int           idx;
        int           acc_at_stall;
        int           ready_at_stall;
        int           ghost;
        logic [2:0]   prev_func;
        logic [W-1:0] prev_x;
        logic [2:0]   bf [7];
        logic [W-1:0] bx [7];
        logic [W-1:0] by [7];
        logic [2:0]   f;
        logic [W-1:0] x;
        logic [W-1:0] y;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_func = '0; cmd_x = '0; cmd_y = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_alu_x", 64'(alu_x), 64'd0);
        chk("rst_alu_y", 64'(alu_y), 64'd0);
        chk("rst_alu_func", 64'(alu_func), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;

        // AND latency and value
        send(3'b000, 32'hF0F0F0F0, 32'hFF00FF00);
        wait_rsp(lat);
        chk("and_latency", 64'(lat), 64'd3);
        chk("and_data", 64'(rsp_data), 64'hF000F000);
        chk("and_err", 64'(rsp_err), 64'd0);
        drain();

        // Back-to-back shifts, three cycles apart
        got_data.delete(); got_cyc.delete();
        send(3'b010, 32'h80000000, 32'd4);
        send(3'b011, 32'h80000000, 32'd4);
        send(3'b100, 32'h80000000, 32'd4);
        drain();
        chk("shift_count", 64'(got_data.size()), 64'd3);
        if (got_data.size() == 3) begin
            chk("shl_data", 64'(got_data[0]), 64'h00000000);
            chk("shr_data", 64'(got_data[1]), 64'h08000000);
            chk("sra_data", 64'(got_data[2]), 64'hF8000000);
            chk("shift_gap0", 64'(got_cyc[1] - got_cyc[0]), 64'd3);
            chk("shift_gap1", 64'(got_cyc[2] - got_cyc[1]), 64'd3);
        end
        send(3'b100, 32'h80000000, 32'd40);
        wait_rsp(lat);
        chk("sra_big_data", 64'(rsp_data), 64'hFFFFFFFF);
        drain();

        // Illegal function leaves the unit inputs alone
        prev_func = alu_func;
        prev_x    = alu_x;
        send(3'b110, 32'h12345678, 32'h0);
        wait_rsp(lat);
        chk("ill_latency", 64'(lat), 64'd2);
        chk("ill_err", 64'(rsp_err), 64'd1);
        chk("ill_data", 64'(rsp_data), 64'd0);
        chk("ill_alu_func", 64'(alu_func), 64'(prev_func));
        chk("ill_alu_x", 64'(alu_x), 64'(prev_x));
        drain();
        send(3'b001, 32'hFFFF0000, 32'h0F0F0F0F);
        wait_rsp(lat);
        chk("xor_data", 64'(rsp_data), 64'hF0F00F0F);
        chk("xor_err", 64'(rsp_err), 64'd0);
        drain();

        // Backpressure: DEPTH+1 accepted while stalled
        for (int i = 0; i < 7; i++) begin
            gen(f, x, y);
            bf[i] = (i == 3) ? 3'b111 : f;
            bx[i] = x;
            by[i] = y;
        end
        rsp_ready = 1'b0; idx = 0; base = rsp_count; acc_at_stall = -1; ready_at_stall = -1;
        cmd_valid = 1'b1; cmd_func = bf[0]; cmd_x = bx[0]; cmd_y = by[0];
        for (int c = 0; c < 100 && idx < 7; c++) begin
            @(negedge clk);
            if (cmd_ready) idx++;
            if (c == 11) begin
                acc_at_stall   = idx;
                ready_at_stall = int'(cmd_ready);
            end
            @(posedge clk); #1;
            if (c == 11) rsp_ready = 1'b1;
            if (idx < 7) begin
                cmd_func = bf[idx]; cmd_x = bx[idx]; cmd_y = by[idx];
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("bp_accepted_at_stall", 64'(acc_at_stall), 64'(DEPTH + 1));
        chk("bp_cmd_ready_at_stall", 64'(ready_at_stall), 64'd0);
        chk("bp_all_accepted", 64'(idx), 64'd7);
        drain();
        chk("bp_rsp_count", 64'(rsp_count - base), 64'd7);

        // Reset while DRIVE with two commands queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gen(f, x, y);
            send(f, x, y);
        end
        wait_rsp(lat);
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("mid_rst_cmd_ready_after", 64'(cmd_ready), 64'd1);
        ghost = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) ghost++;
        end
        chk("mid_rst_no_ghost", 64'(ghost), 64'd0);
        @(posedge clk); #1;
        send(3'b000, 32'hA5A5A5A5, 32'h0FF00FF0);
        wait_rsp(lat);
        chk("post_rst_and_latency", 64'(lat), 64'd3);
        chk("post_rst_and_data", 64'(rsp_data), 64'h05A005A0);
        drain();

        // Random stream over several pointer wraps with random backpressure
        base = rsp_count;
        fork
            begin
                logic [2:0]   rf;
                logic [W-1:0] rx;
                logic [W-1:0] ry;
                for (int i = 0; i < 3 * DEPTH; i++) begin
                    gen(rf, rx, ry);
                    send(rf, rx, ry);
                end
            end
            begin
                repeat (120) begin
                    @(posedge clk); #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        drain();
        chk("stream_rsp_count", 64'(rsp_count - base), 64'(3 * DEPTH));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
